// File: rtl/lisnoc16_pkg.sv
// Shared debug-NoC (lisnoc16) definitions: flit types, message classes and field layout.
package lisnoc16_pkg;

  localparam int DBG_TIMESTAMP_WIDTH = 32;
  localparam int FLIT_WIDTH          = 18;

  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEADER  = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_t;

  localparam logic [2:0] CLASS_NRM = 3'b010;

  typedef struct packed {
    flit_type_t  ftype;
    logic [15:0] data;
  } flit_t;

  typedef struct packed {
    logic [4:0] dest;
    logic [2:0] msg_class;
    logic [7:0] src;
  } hdr_t;

endpackage

// File: rtl/nrm_sample_fifo.sv
// Small sample FIFO with show-ahead read data; pop_dat is valid whenever empty is low.
module nrm_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/nrm_trace_packetizer.sv
// Packs link-statistics samples into debug-NoC packets; samples are buffered and
// dropped (with a saturating count) when the buffer is full, since the source cannot stall.
module nrm_trace_packetizer
  import lisnoc16_pkg::*;
#(
  parameter int         MONITORED_LINK_COUNT = 4,
  parameter int         TIMESTAMP_WIDTH      = DBG_TIMESTAMP_WIDTH,
  parameter int         FIFO_DEPTH           = 2,
  parameter logic [4:0] DEST_ID              = 5'd0,
  parameter logic [7:0] SRC_ID               = 8'd0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [TIMESTAMP_WIDTH+8*MONITORED_LINK_COUNT-1:0] trace_in,
  input  logic                                          trace_in_valid,
  output logic [FLIT_WIDTH-1:0]                         dbgnoc_out_flit,
  output logic                                          dbgnoc_out_valid,
  input  logic                                          dbgnoc_out_ready,
  output logic [7:0]                                    drop_count
);

  localparam int N  = MONITORED_LINK_COUNT;
  localparam int SW = TIMESTAMP_WIDTH + 8 * N;
  localparam int LF = (N + 1) / 2;

  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_INFO, ST_TSTAMP, ST_LINKS} state_t;

  state_t                     state_q, state_d;
  logic [4:0]                 idx_q, idx_d;
  logic [SW-1:0]              sample_q, sample_d, fifo_dat;
  logic [7:0]                 drop_q, snap_q, snap_d;
  logic [TIMESTAMP_WIDTH-1:0] ts;
  logic [16*LF-1:0]           links_pad;
  flit_t                      flit_q, flit_d;
  hdr_t                       hdr;
  logic                       valid_q, fire, pop, push, drop, full, empty;

  assign fire = valid_q & dbgnoc_out_ready;
  assign pop  = (state_q == ST_IDLE) & ~empty;
  assign push = trace_in_valid & (~full | pop);
  assign drop = trace_in_valid & full & ~pop;

  nrm_sample_fifo #(.WIDTH(SW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (trace_in),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (full),
    .empty    (empty)
  );

  // A drop coinciding with the snapshot clear must survive as a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          drop_q <= '0;
    else if (pop)                     drop_q <= {7'd0, drop};
    else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      sample_q <= '0;
      snap_q   <= '0;
      flit_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      snap_q   <= snap_d;
      flit_q   <= flit_d;
      valid_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE:   if (!empty) state_d = ST_HEADER;
      ST_HEADER: if (fire) state_d = ST_INFO;
      ST_INFO:   if (fire) begin
        state_d = ST_TSTAMP;
        idx_d   = '0;
      end
      ST_TSTAMP: if (fire) begin
        if (idx_q == 5'd1) begin
          state_d = ST_LINKS;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_LINKS:  if (fire) begin
        if (idx_q == 5'(LF - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // The flit for the upcoming state is built here and registered, so it stays put while stalled.
  always_comb begin
    sample_d      = pop ? fifo_dat : sample_q;
    snap_d        = pop ? drop_q : snap_q;
    ts            = sample_d[8*N +: TIMESTAMP_WIDTH];
    links_pad     = (16*LF)'(sample_d[8*N-1:0]);
    hdr.dest      = DEST_ID;
    hdr.msg_class = CLASS_NRM;
    hdr.src       = SRC_ID;
    flit_d        = '0;
    case (state_d)
      ST_HEADER: begin
        flit_d.ftype = FLIT_HEADER;
        flit_d.data  = hdr;
      end
      ST_INFO: begin
        flit_d.ftype = FLIT_PAYLOAD;
        flit_d.data  = {snap_d, 8'(N)};
      end
      ST_TSTAMP: begin
        flit_d.ftype = FLIT_PAYLOAD;
        flit_d.data  = (idx_d == 5'd0) ? ts[31:16] : ts[15:0];
      end
      ST_LINKS: begin
        flit_d.ftype = (idx_d == 5'(LF - 1)) ? FLIT_LAST : FLIT_PAYLOAD;
        flit_d.data  = {links_pad[16*idx_d +: 8], links_pad[16*idx_d + 8 +: 8]};
      end
      default: flit_d = '0;
    endcase
  end

  assign dbgnoc_out_flit  = flit_q;
  assign dbgnoc_out_valid = valid_q;
  assign drop_count       = drop_q;

endmodule
